// File: rtl/vector_multiplier_pkg.sv
// Shared types and helpers for vector_transformer: FSM state encoding,
// accumulator width rule and result narrowing (saturate or wrap).
// Narrowing behaviour is selected by macro VECTOR_TRANSFORMER_SATURATE_EN.
package vector_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Common width the narrowing helper works at; any accumulator up to this
  // width is sign-extended into it by the caller.
  localparam int NARROW_W = 128;

  // Full-precision dot product: 2*W for the product, clog2(N) for the sum of
  // N products, plus one guard bit.
  function automatic int acc_width(input int elem_w, input int n);
    return 2 * elem_w + $clog2(n) + 1;
  endfunction

  // Reduces a sign-extended value to elem_w significant bits, returned still
  // sign-extended at NARROW_W so the caller only has to keep the low bits.
  function automatic logic signed [NARROW_W-1:0] narrow_result(
    input logic signed [NARROW_W-1:0] val,
    input int                         elem_w
  );
`ifdef VECTOR_TRANSFORMER_SATURATE_EN
    logic signed [NARROW_W-1:0] one;
    logic signed [NARROW_W-1:0] max_v;
    logic signed [NARROW_W-1:0] min_v;
    one   = NARROW_W'(1);
    max_v = (one <<< (elem_w - 1)) - one;
    min_v = -(one <<< (elem_w - 1));
    if (val > max_v) return max_v;
    if (val < min_v) return min_v;
    return val;
`else
    // Two's-complement wrap: keep the low elem_w bits, re-extend their sign.
    return (val <<< (NARROW_W - elem_w)) >>> (NARROW_W - elem_w);
`endif
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Purpose: registered signed multiply-accumulate with synchronous clear.
// Latency: accumulator updates one cycle after i_en; o_acc_next is the
//          combinational value the accumulator will take (acc + a*b).
// Backpressure: none; i_en gates accumulation, i_clr has priority.
// Ports: clk, i_rst_n (sync, active-low), i_clr, i_en, i_a/i_b (signed
//        operands), o_acc_next (signed, ACC_WIDTH bits).
module mac_unit #(
  parameter int ELEMENT_WIDTH = 24,
  parameter int ACC_WIDTH     = 51
) (
  input  logic                            clk,
  input  logic                            i_rst_n,
  input  logic                            i_clr,
  input  logic                            i_en,
  input  logic signed [ELEMENT_WIDTH-1:0] i_a,
  input  logic signed [ELEMENT_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0]     o_acc_next
);

  localparam int PROD_W = 2 * ELEMENT_WIDTH;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [PROD_W-1:0]    w_prod;

  assign w_prod     = i_a * i_b;
  assign o_acc_next = r_acc + {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/vector_transformer.sv
// Purpose: y = M*v for an NxN signed coefficient matrix, one element per
//          write strobe into a result RAM.
// Latency: N*(N+1) cycles per vector; first wr_en N+1 cycles after the
//          cycle in which a buffered vector is taken (MAC entry).
// Backpressure: one-entry pending buffer; ready = buffer empty and not done.
//          A vector offered while the buffer is full is dropped and
//          overflow_err latches.
// Ports: clk, reset (sync, active-low); matrix_we/row/col/data coefficient
//        write (IDLE with empty buffer only); vector_in/vector_valid/
//        vector_done from the vector constructor; ready back to it;
//        wr_en/wr_addr/wr_data result RAM write; results_written count;
//        overflow_err sticky; done level in FINISH.
// Config: define VECTOR_TRANSFORMER_SATURATE_EN to clamp results to the
//        element range; otherwise results wrap to ELEMENT_WIDTH bits.
module vector_transformer
  import vector_multiplier_pkg::*;
#(
  parameter int  ELEMENT_WIDTH    = 24,
  parameter int  ADDR_WIDTH       = 17,
  parameter int  VECTOR_DIMENSION = 3,
  parameter int  FRAC_BITS        = 0,
  localparam int IDX_W            = (VECTOR_DIMENSION > 1) ? $clog2(VECTOR_DIMENSION) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      matrix_we,
  input  logic [IDX_W-1:0]                          matrix_row,
  input  logic [IDX_W-1:0]                          matrix_col,
  input  logic [ELEMENT_WIDTH-1:0]                  matrix_data,
  input  logic [VECTOR_DIMENSION*ELEMENT_WIDTH-1:0] vector_in,
  input  logic                                      vector_valid,
  input  logic                                      vector_done,
  output logic                                      ready,
  output logic                                      wr_en,
  output logic [ADDR_WIDTH-1:0]                     wr_addr,
  output logic [ELEMENT_WIDTH-1:0]                  wr_data,
  output logic [ADDR_WIDTH-1:0]                     results_written,
  output logic                                      overflow_err,
  output logic                                      done
);

  localparam int N     = VECTOR_DIMENSION;
  localparam int EW    = ELEMENT_WIDTH;
  localparam int ACC_W = acc_width(ELEMENT_WIDTH, VECTOR_DIMENSION);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [EW-1:0] COEF_ONE = EW'(1) << FRAC_BITS;

  state_t                 r_state;
  logic                   r_buf_full;
  logic [N*EW-1:0]        r_buf;
  logic signed [EW-1:0]   r_vec [N];
  logic signed [EW-1:0]   r_m   [N][N];
  logic [IDX_W-1:0]       r_row;
  logic [IDX_W-1:0]       r_col;
  logic [ADDR_WIDTH-1:0]  r_results_written;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic                   r_wr_en;
  logic [EW-1:0]          r_wr_data;
  logic                   r_overflow;
  logic                   r_done;

  logic signed [EW-1:0]    w_coef;
  logic signed [EW-1:0]    w_elem;
  logic                    w_mac_en;
  logic                    w_mac_clr;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_acc_shifted;
  logic [EW-1:0]           w_result;

  assign w_coef    = r_m[r_row][r_col];
  assign w_elem    = r_vec[r_col];
  assign w_mac_en  = (r_state == S_MAC);
  // Accumulator is held at zero whenever we are not accumulating, so every
  // row starts clean on its first MAC cycle.
  assign w_mac_clr = !w_mac_en;

  mac_unit #(
    .ELEMENT_WIDTH (EW),
    .ACC_WIDTH     (ACC_W)
  ) u_mac (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_clr      (w_mac_clr),
    .i_en       (w_mac_en),
    .i_a        (w_coef),
    .i_b        (w_elem),
    .o_acc_next (w_acc_next)
  );

  // The result is captured from the accumulator's next value on the last MAC
  // cycle so wr_data is registered and aligned with wr_en in WRITE.
  assign w_acc_shifted = w_acc_next >>> FRAC_BITS;
  assign w_result      = EW'(narrow_result(NARROW_W'(w_acc_shifted), EW));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_buf_full        <= 1'b0;
      r_buf             <= '0;
      r_row             <= '0;
      r_col             <= '0;
      r_results_written <= '0;
      r_wr_addr         <= '0;
      r_wr_en           <= 1'b0;
      r_wr_data         <= '0;
      r_overflow        <= 1'b0;
      r_done            <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_vec[i] <= '0;
        for (int j = 0; j < N; j++) begin
          r_m[i][j] <= (i == j) ? COEF_ONE : '0;
        end
      end
    end else begin
      r_wr_en <= 1'b0;

      // Pending buffer fill; a full buffer keeps its contents. Emptying is
      // done by the FSM below and only ever happens when the buffer is full,
      // so it never collides with a load.
      if (vector_valid) begin
        if (r_buf_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_buf      <= vector_in;
          r_buf_full <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          // Coefficients only change while no vector is pending or in flight.
          if (matrix_we && !r_buf_full) begin
            r_m[matrix_row][matrix_col] <= matrix_data;
          end
          if (r_buf_full) begin
            for (int i = 0; i < N; i++) begin
              r_vec[i] <= r_buf[i*EW +: EW];
            end
            r_buf_full <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_state    <= S_MAC;
          end else if (vector_done && !vector_valid) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end

        S_MAC: begin
          if (r_col == LAST_IDX) begin
            r_col     <= '0;
            r_wr_en   <= 1'b1;
            r_wr_data <= w_result;
            r_wr_addr <= r_results_written;
            r_state   <= S_WRITE;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end

        S_WRITE: begin
          r_results_written <= r_results_written + 1'b1;
          if (r_row == LAST_IDX) begin
            r_row <= '0;
            // Chain straight into the next vector to avoid an idle gap.
            if (r_buf_full) begin
              for (int i = 0; i < N; i++) begin
                r_vec[i] <= r_buf[i*EW +: EW];
              end
              r_buf_full <= 1'b0;
              r_state    <= S_MAC;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_row   <= r_row + 1'b1;
            r_state <= S_MAC;
          end
        end

        S_FINISH: begin
          r_state <= S_FINISH;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready           = !r_buf_full && !r_done;
  assign wr_en           = r_wr_en;
  assign wr_addr         = r_wr_addr;
  assign wr_data         = r_wr_data;
  assign results_written = r_results_written;
  assign overflow_err    = r_overflow;
  assign done            = r_done;

endmodule

// File: tb/tb_vector_transformer.sv
module tb_vector_transformer;

  localparam int EW = 24;
  localparam int AW = 17;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            matrix_we = 1'b0;
  logic [1:0]      matrix_row = '0;
  logic [1:0]      matrix_col = '0;
  logic [EW-1:0]   matrix_data = '0;
  logic [N*EW-1:0] vector_in = '0;
  logic            vector_valid = 1'b0;
  logic            vector_done = 1'b0;
  logic            ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [EW-1:0]   wr_data;
  logic [AW-1:0]   results_written;
  logic            overflow_err;
  logic            done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  vector_transformer #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(N), .FRAC_BITS(0)
  ) dut (
    .clk(clk), .reset(reset),
    .matrix_we(matrix_we), .matrix_row(matrix_row), .matrix_col(matrix_col),
    .matrix_data(matrix_data),
    .vector_in(vector_in), .vector_valid(vector_valid), .vector_done(vector_done),
    .ready(ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .results_written(results_written), .overflow_err(overflow_err), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [EW-1:0] data;
  } wr_t;
  wr_t wq[$];

  // Write observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      e.cyc  = cyc;
      e.addr = wr_addr;
      e.data = wr_data;
      wq.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; vector_valid = 1'b0; vector_done = 1'b0; matrix_we = 1'b0;
    tick(); tick();
    reset = 1'b1;
    wq.delete();
  endtask

  // Offers one vector for one cycle; t0 is the MAC entry cycle if accepted.
  task automatic send_vector(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                             input logic [EW-1:0] e2, output int t0);
    vector_in = {e2, e1, e0};
    vector_valid = 1'b1;
    t0 = cyc + 1;
    tick();
    vector_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [1:0] r, input logic [1:0] c, input logic [EW-1:0] d);
    matrix_row = r; matrix_col = c; matrix_data = d; matrix_we = 1'b1;
    tick();
    matrix_we = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int i = 0;
    while (wq.size() < n && i < budget) begin
      tick();
      i++;
    end
    ok = (wq.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    tests_run++; if (overflow_err !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
    tests_run++; if (results_written !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", results_written); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
  endtask

  task automatic test_identity();
    int t0;
    bit ok;
    logic [EW-1:0] exp_d [3];
    exp_d[0] = 24'd5; exp_d[1] = -24'sd7; exp_d[2] = 24'd9;
    do_reset();
    send_vector(24'd5, -24'sd7, 24'd9, t0);
    wait_writes(3, 60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ident_timeout: got %0d writes want 3", wq.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (wq[i].cyc !== t0 + 4*(i+1)) begin tests_failed++; $display("FAIL ident_cycle%0d: got +%0d want +%0d", i, wq[i].cyc - t0, 4*(i+1)); end
        tests_run++; if (wq[i].data !== exp_d[i]) begin tests_failed++; $display("FAIL ident_data%0d: got %0d want %0d", i, $signed(wq[i].data), $signed(exp_d[i])); end
        tests_run++; if (wq[i].addr !== AW'(i)) begin tests_failed++; $display("FAIL ident_addr%0d: got %0d want %0d", i, wq[i].addr, i); end
      end
    end
    tick_n(2);
    tests_run++; if (results_written !== AW'(3)) begin tests_failed++; $display("FAIL ident_count: got %0d want 3", results_written); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    bit ok;
    int m_tab [9];
    logic [EW-1:0] exp_d [6];
    m_tab = '{1, 2, 3, 0, 1, 0, -1, 0, 2};
    exp_d[0] = 24'd6; exp_d[1] = 24'd1; exp_d[2] = 24'd1;
    exp_d[3] = 24'd9; exp_d[4] = -24'sd1; exp_d[5] = 24'd4;
    do_reset();
    for (int i = 0; i < 9; i++) write_coef(2'(i / 3), 2'(i % 3), EW'(m_tab[i]));
    send_vector(24'd1, 24'd1, 24'd1, t0);
    tick();
    send_vector(24'd2, -24'sd1, 24'd3, t1);
    wait_writes(6, 100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: got %0d writes want 6", wq.size()); end
    if (ok) begin
      tests_run++; if (wq[0].cyc !== t0 + 4) begin tests_failed++; $display("FAIL b2b_first_cycle: got +%0d want +4", wq[0].cyc - t0); end
      for (int i = 0; i < 6; i++) begin
        tests_run++; if (wq[i].data !== exp_d[i]) begin tests_failed++; $display("FAIL b2b_data%0d: got %0d want %0d", i, $signed(wq[i].data), $signed(exp_d[i])); end
        tests_run++; if (wq[i].addr !== AW'(i)) begin tests_failed++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, wq[i].addr, i); end
      end
      for (int i = 1; i < 6; i++) begin
        tests_run++; if (wq[i].cyc - wq[i-1].cyc !== 4) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d want 4", i, wq[i].cyc - wq[i-1].cyc); end
      end
    end
    tick_n(2);
    tests_run++; if (results_written !== AW'(6)) begin tests_failed++; $display("FAIL b2b_count: got %0d want 6", results_written); end
    tests_run++; if (overflow_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_overflow: got %b want 0", overflow_err); end
  endtask

  task automatic test_overflow();
    int t0;
    int tx;
    bit ok;
    do_reset();
    send_vector(24'd1, 24'd2, 24'd3, t0);
    // Buffer is still full in this cycle; this vector must be dropped.
    send_vector(24'd100, 24'd100, 24'd100, tx);
    tests_run++; if (overflow_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
    wait_writes(3, 60, ok);
    tick_n(20);
    tests_run++; if (wq.size() !== 3) begin tests_failed++; $display("FAIL ovf_write_count: got %0d want 3", wq.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (wq[i].data !== EW'(i + 1)) begin tests_failed++; $display("FAIL ovf_data%0d: got %0d want %0d", i, $signed(wq[i].data), i + 1); end
      end
    end
    tests_run++; if (results_written !== AW'(3)) begin tests_failed++; $display("FAIL ovf_count: got %0d want 3", results_written); end
    tests_run++; if (overflow_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
  endtask

  // Runs on top of the state left by test_overflow (count 3, overflow set).
  task automatic test_mid_reset();
    int t0;
    wq.delete();
    send_vector(24'd4, 24'd5, 24'd6, t0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL mrst_wr_en: got %b want 0", wr_en); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL mrst_ready: got %b want 1", ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mrst_done: got %b want 0", done); end
    tests_run++; if (overflow_err !== 1'b0) begin tests_failed++; $display("FAIL mrst_overflow: got %b want 0", overflow_err); end
    tests_run++; if (results_written !== '0) begin tests_failed++; $display("FAIL mrst_count: got %0d want 0", results_written); end
    tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL mrst_wr_addr: got %0d want 0", wr_addr); end
    tests_run++; if (wr_data !== '0) begin tests_failed++; $display("FAIL mrst_wr_data: got %0d want 0", wr_data); end
    reset = 1'b1;
    tick_n(20);
    tests_run++; if (wq.size() !== 0) begin tests_failed++; $display("FAIL mrst_no_write: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_saturate();
    int t0;
    bit ok;
    logic [EW-1:0] exp0;
`ifdef VECTOR_TRANSFORMER_SATURATE_EN
    exp0 = 24'd8388607;
`else
    exp0 = 24'd1;
`endif
    do_reset();
    write_coef(2'd0, 2'd0, 24'h7FFFFF);
    send_vector(24'h7FFFFF, 24'd0, 24'd0, t0);
    wait_writes(3, 60, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL sat_timeout: got %0d writes want 3", wq.size()); end
    if (ok) begin
      tests_run++; if (wq[0].data !== exp0) begin tests_failed++; $display("FAIL sat_row0: got %0d want %0d", wq[0].data, exp0); end
      tests_run++; if (wq[1].data !== '0) begin tests_failed++; $display("FAIL sat_row1: got %0d want 0", wq[1].data); end
      tests_run++; if (wq[2].data !== '0) begin tests_failed++; $display("FAIL sat_row2: got %0d want 0", wq[2].data); end
    end
  endtask

  task automatic test_done();
    do_reset();
    vector_done = 1'b1;
    tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_level: got %b want 1", done); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL done_ready: got %b want 0", ready); end
    vector_done = 1'b0;
    tick_n(5);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_hold: got %b want 1", done); end
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL done_wr_en: got %b want 0", wr_en); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_saturate();
    test_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vector_transformer.md
VECTOR_TRANSFORMER -- requirements
Module: vector_transformer

Interface
REQ-001 SHALL provide parameters:
- ELEMENT_WIDTH, default 24: signed element/coefficient width.
- ADDR_WIDTH, default 17: result write address width.
- VECTOR_DIMENSION, default 3: elements per vector, N.
- FRAC_BITS, default 0: fractional bits of the coefficients.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1: the only clock.
- reset, in, 1: synchronous, active-low.
- matrix_we, in, 1: coefficient write strobe.
- matrix_row, in, clog2(N): coefficient row.
- matrix_col, in, clog2(N): coefficient column.
- matrix_data, in, ELEMENT_WIDTH: coefficient value.
- vector_in, in, ELEMENT_WIDTH x N: input vector from the vector constructor.
- vector_valid, in, 1: one-cycle strobe that vector_in is valid.
- vector_done, in, 1: level; the constructor has consumed all expected elements.
- ready, out, 1: drives the constructor's enabled input.
- wr_en, out, 1: result RAM write strobe.
- wr_addr, out, ADDR_WIDTH: result RAM write address.
- wr_data, out, ELEMENT_WIDTH: result element.
- results_written, out, ADDR_WIDTH: count of result elements written.
- overflow_err, out, 1: sticky; a vector arrived while the buffer was full.
- done, out, 1: level; all results written.

Function
REQ-003 SHALL compute y = M·v, with M an N x N signed coefficient matrix and v the input vector.
REQ-004 SHALL hold a one-entry pending buffer; vector_valid loads it when empty. ready = buffer empty AND not done.
REQ-005 SHALL set overflow_err and drop the vector on vector_valid while the buffer is full; the buffered vector is unchanged.
REQ-006 SHALL use states IDLE, MAC, WRITE, FINISH.
- IDLE->MAC when the buffer is full: copy the buffer to the working register, empty the buffer, row=0, col=0, acc=0.
- MAC: one multiply-accumulate per cycle, acc += M[row][col]*v[col], for N cycles.
- MAC->WRITE after col=N-1.
- WRITE: one cycle; wr_en=1, wr_data=result(acc), wr_addr=results_written, then increment results_written.
- WRITE->MAC for the next row. After row N-1: go to MAC if the buffer is full, else IDLE.
- IDLE->FINISH when vector_done=1, the buffer is empty and no vector_valid is present in that cycle.
- FINISH holds until reset; done=1 in FINISH only.
REQ-007 SHALL take N*(N+1) cycles per vector. The first wr_en occurs N+1 cycles after the MAC entry cycle. Back-to-back vectors have no idle gap.
REQ-008 SHALL use an accumulator of 2*ELEMENT_WIDTH+clog2(N)+1 bits with signed products. result = acc arithmetically shifted right by FRAC_BITS, then narrowed per REQ-013.
REQ-009 SHALL wrap wr_addr and results_written from 2^ADDR_WIDTH-1 to 0.
REQ-010 SHALL apply matrix_we only in IDLE with the buffer empty; it is ignored otherwise. A write and vector_valid in the same cycle: both take effect, and the write precedes use.
REQ-011 SHALL drive wr_en=0 in every state except WRITE.

Reset
REQ-012 SHALL, on reset=0 at a clk edge, and regardless of state:
- go to state IDLE and empty the buffer;
- clear acc, row, col, results_written, wr_addr, wr_data, wr_en, overflow_err and done;
- set ready=1;
- load M with identity scaled by 2^FRAC_BITS.
A mid-vector reset discards the partial result with no further wr_en.

Configuration
REQ-013 SHALL honour macro VECTOR_TRANSFORMER_SATURATE_EN.
- Defined: clamp the result to [-2^(ELEMENT_WIDTH-1), 2^(ELEMENT_WIDTH-1)-1].
- Undefined: truncate to the low ELEMENT_WIDTH bits (two's-complement wrap).

Structure
REQ-014 SHALL place the state enum typedef and the accumulator-width/result-narrowing helper in shared package vector_multiplier_pkg.
REQ-015 SHALL instantiate one sub-module, mac_unit: registered signed multiply-accumulate with a clear input.

Verification
REQ-016 Bench SHALL cover:
- Identity M, N=3, v=(5,-7,9) -> wr_en pulses 4, 8, 12 cycles after MAC entry, with wr_data 5, -7, 9 and wr_addr 0, 1, 2.
- M rows (1,2,3),(0,1,0),(-1,0,2), v=(1,1,1) -> results 6, 1, 1. Two back-to-back vectors -> results_written=6 with no gap between vectors.
- Second vector_valid while the buffer is full -> overflow_err=1, the vector is dropped, and the earlier results are unaffected.
- M[0][0]=2^23-1 with v=(2^23-1,0,0) -> 8388607 with the saturate macro defined; 1 without it.
- Reset asserted in the second MAC cycle -> no wr_en; all outputs at reset values one cycle later. vector_done=1 with the buffer empty -> done=1 and ready=0.
